// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the latency-modelled data memory target.
package dmem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int LAT_W   = 4;
  localparam int WADDR_W = 30;

  // Misaligned or beyond the last word; the full word index is compared, no wrap.
  function automatic logic addr_err(input logic [31:0] addr, input int depth_words);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= WADDR_W'(depth_words));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Registered read of the addressed word, plus optional write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
    rdata <= mem_r[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store target with fixed access latency, one transaction in flight,
// and error responses for misaligned or out-of-range addresses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [1:0]       state_r;
  logic [LAT_W-1:0] cnt_r;
  logic             wr_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic             resp_valid_r;
  logic             resp_err_r;
  logic [31:0]      resp_rdata_r;

  logic             err_s;
  logic             fire_s;
  logic             ram_we_s;
  logic [IDX_W-1:0] ram_idx_s;
  logic [31:0]      ram_rdata_s;

  // Access decode; the RAM is pointed at the incoming address while idle so
  // its registered read is already valid by the final WAIT edge, even for LATENCY=1.
  always_comb begin
    err_s    = addr_err(addr_r, DEPTH_WORDS);
    fire_s   = (state_r == WAIT) && (cnt_r == {LAT_W{1'b0}});
    ram_we_s = fire_s && wr_r && !err_s;
    if (state_r == IDLE) begin
      ram_idx_s = req_addr[IDX_W+1:2];
    end else begin
      ram_idx_s = addr_r[IDX_W+1:2];
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we_s),
    .idx   (ram_idx_s),
    .wdata (wdata_r),
    .rdata (ram_rdata_s)
  );

  // Transaction FSM: accept, count down the latency, then hold the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= {LAT_W{1'b0}};
      wr_r         <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            wr_r    <= req_write;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            cnt_r   <= LAT_W'(LATENCY - 1);
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (fire_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= err_s;
            resp_rdata_r <= (wr_r || err_s) ? 32'h0000_0000 : ram_rdata_s;
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r - LAT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for two builds (LATENCY=3 and LATENCY=1)
// against a word-array reference model.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int total = 0;
  int bad   = 0;
  logic [31:0] model [2][16];

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on build sel, with bp cycles of response backpressure.
  task automatic txn(input int sel, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input int bp);
    int          lat;
    int          k;
    logic        err;
    logic [31:0] exp_rd;
    lat    = (sel == 1) ? 1 : 3;
    err    = (addr % 4 != 0) || ((addr / 4) >= 1024);
    exp_rd = (err || wr) ? 32'h0 : model[sel][(addr / 4) % 16];
    check("ready_before_req", {31'b0, req_ready[sel]}, 32'd1);
    req_valid[sel] = 1'b1;
    req_write[sel] = wr;
    req_addr[sel]  = addr;
    req_wdata[sel] = wd;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    if (wr && !err) model[sel][(addr / 4) % 16] = wd;
    k = 0;
    while (resp_valid[sel] !== 1'b1 && k < 20) begin
      check("ready_low_busy", {31'b0, req_ready[sel]}, 32'd0);
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, lat);
    check("resp_err", {31'b0, resp_err[sel]}, {31'b0, err});
    check("resp_rdata", resp_rdata[sel], exp_rd);
    for (int i = 0; i < bp; i++) begin
      req_valid[sel] = 1'b1;
      req_write[sel] = 1'b1;
      req_addr[sel]  = 32'h0;
      req_wdata[sel] = $urandom;
      @(posedge clk); #1;
      check("bp_valid_held", {31'b0, resp_valid[sel]}, 32'd1);
      check("bp_rdata_held", resp_rdata[sel], exp_rd);
      check("bp_err_held", {31'b0, resp_err[sel]}, {31'b0, err});
      check("bp_ready_low", {31'b0, req_ready[sel]}, 32'd0);
    end
    req_valid[sel]  = 1'b0;
    resp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    resp_ready[sel] = 1'b0;
    check("hs_valid_clear", {31'b0, resp_valid[sel]}, 32'd0);
    check("hs_rdata_clear", resp_rdata[sel], 32'h0);
    check("hs_err_clear", {31'b0, resp_err[sel]}, 32'd0);
    check("hs_ready_back", {31'b0, req_ready[sel]}, 32'd1);
  endtask

  initial begin
    int r;
    int s;
    logic [31:0] a;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0; resp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_resp_valid", {31'b0, resp_valid[i]}, 32'd0);
      check("rst_resp_rdata", resp_rdata[i], 32'h0);
      check("rst_resp_err", {31'b0, resp_err[i]}, 32'd0);
      check("rst_req_ready", {31'b0, req_ready[i]}, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    // Give every tracked word a known value in both builds.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++)
        txn(i, 1'b1, 32'(w * 4), $urandom, 0);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 0);
    txn(0, 1'b0, 32'h13, 32'h0, 0);
    txn(0, 1'b1, 32'h1000, 32'h5555AAAA, 0);
    txn(0, 1'b1, 32'hFFFFFFFC, 32'h12345678, 0);
    txn(0, 1'b0, 32'h0, 32'h0, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 5);
    txn(0, 1'b0, 32'h0, 32'h0, 0);

    // Abort a store in WAIT with reset; the old word must survive.
    txn(0, 1'b1, 32'h20, 32'h11111111, 0);
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = 32'h20; req_wdata[0] = 32'h22222222;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h20, 32'h0, 0);

    txn(1, 1'b1, 32'h4, 32'hA5A5A5A5, 0);
    txn(1, 1'b0, 32'h4, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      s = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 15) * 4);
      else if (r < 9)  a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             a = 32'h1000 + ($urandom & 32'h0FFFFFFC);
      txn(s, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
